// File: rtl/axi_bridge_pkg.sv
// Shared constants, FSM state types and the request-type to AXI len/size mapping
// for the cache-to-AXI3 bridge.
package axi_bridge_pkg;

    localparam logic [2:0] TYPE_BYTE = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
    localparam logic [2:0] TYPE_WORD = 3'b010;
    localparam logic [2:0] TYPE_LINE = 3'b100;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_AR,
        RD_R
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SEND,
        WR_B
    } wr_state_t;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
    } len_size_t;

    // Line requests become a 4-beat word burst; everything else is one beat of its own size.
    function automatic len_size_t type_to_len_size(input logic [2:0] req_type);
        len_size_t ls;
        if (req_type == TYPE_LINE) begin
            ls.len  = 8'd3;
            ls.size = 3'd2;
        end else begin
            ls.len  = '0;
            ls.size = {1'b0, req_type[1:0]};
        end
        return ls;
    endfunction

endpackage

// File: rtl/bridge_wr_buffer.sv
// Write-data buffer: latches the 128-bit line at acceptance and serves it as
// W beats word0..word3 (line) or a single strobed word.
module bridge_wr_buffer
    import axi_bridge_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [2:0]   load_type,
    input  logic [3:0]   load_wstrb,
    input  logic [127:0] load_data,
    input  logic         beat_fire,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast
);

    logic [127:0] line_q;
    logic         is_line;
    logic [3:0]   wstrb_q;
    logic [1:0]   beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q  <= '0;
            is_line <= 1'b0;
            wstrb_q <= '0;
            beat    <= '0;
        end else if (load) begin
            line_q  <= load_data;
            is_line <= (load_type == TYPE_LINE);
            wstrb_q <= load_wstrb;
            beat    <= '0;
        end else if (beat_fire) begin
            beat <= wlast ? 2'd0 : beat + 2'd1;
        end
    end

    always_comb begin
        wdata = line_q[31:0];
        case (beat)
            2'd0: wdata = line_q[31:0];
            2'd1: wdata = line_q[63:32];
            2'd2: wdata = line_q[95:64];
            2'd3: wdata = line_q[127:96];
            default: wdata = line_q[31:0];
        endcase
    end

    assign wstrb = is_line ? 4'hf : wstrb_q;
    assign wlast = is_line ? (beat == 2'd3) : 1'b1;

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache request/return interface to a single AXI3 master port; one read and one write in flight.
// Optional macro BRIDGE_RAW_LINE_CHECK_EN narrows the read-after-write block to the same cache line.
module cache_axi_bridge
    import axi_bridge_pkg::*;
(
    input  logic         clk,
    input  logic         reset,

    input  logic         inst_rd_req,
    input  logic [2:0]   inst_rd_type,
    input  logic [31:0]  inst_rd_addr,
    output logic         inst_rd_rdy,
    output logic         inst_ret_valid,
    output logic [1:0]   inst_ret_last,
    output logic [31:0]  inst_ret_data,

    input  logic         data_rd_req,
    input  logic [2:0]   data_rd_type,
    input  logic [31:0]  data_rd_addr,
    output logic         data_rd_rdy,
    output logic         data_ret_valid,
    output logic [1:0]   data_ret_last,
    output logic [31:0]  data_ret_data,

    input  logic         data_wr_req,
    input  logic [2:0]   data_wr_type,
    input  logic [31:0]  data_wr_addr,
    input  logic [3:0]   data_wr_wstrb,
    input  logic [127:0] data_wr_data,
    output logic         data_wr_rdy,

    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [1:0]   arlock,
    output logic [3:0]   arcache,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,

    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,

    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,

    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,

    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;

    logic      raw_block;
    logic      rd_accept;
    logic      wr_accept;
    logic      aw_done, w_done;
    logic      aw_hs, w_last_hs;
    len_size_t rd_ls, wr_ls;

    logic unused_ok;
    assign unused_ok = ^{rresp, rid[3:1], bid, bresp};

    // ---------------- read-after-write hazard ----------------
`ifdef BRIDGE_RAW_LINE_CHECK_EN
    always_comb begin
        raw_block = ((wr_state != WR_IDLE) && (data_rd_addr[31:4] == awaddr[31:4]))
                 || (data_wr_req && (data_rd_addr[31:4] == data_wr_addr[31:4]));
    end
`else
    always_comb begin
        raw_block = (wr_state != WR_IDLE) || data_wr_req;
    end
`endif

    // ---------------- read arbitration ----------------
    always_comb begin
        data_rd_rdy = (rd_state == RD_IDLE) && data_rd_req && !raw_block && !reset;
        inst_rd_rdy = (rd_state == RD_IDLE) && inst_rd_req && !data_rd_rdy && !reset;
        rd_accept   = data_rd_rdy || inst_rd_rdy;
        rd_ls       = type_to_len_size(data_rd_rdy ? data_rd_type : inst_rd_type);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arid   <= '0;
            araddr <= '0;
            arlen  <= '0;
            arsize <= '0;
        end else if (rd_accept) begin
            arid   <= data_rd_rdy ? ID_DATA : ID_INST;
            araddr <= data_rd_rdy ? data_rd_addr : inst_rd_addr;
            arlen  <= rd_ls.len;
            arsize <= rd_ls.size;
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_state <= RD_IDLE;
        else       rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        arvalid = 1'b0;
        rready  = 1'b0;
        case (rd_state)
            RD_IDLE: if (rd_accept) rd_next = RD_AR;
            RD_AR: begin
                arvalid = 1'b1;
                if (arready) rd_next = RD_R;
            end
            RD_R: begin
                rready = 1'b1;
                if (rvalid && rlast) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    // ---------------- read return routing ----------------
    assign inst_ret_valid = rvalid && rready && (rid[0] == ID_INST[0]);
    assign data_ret_valid = rvalid && rready && (rid[0] == ID_DATA[0]);
    assign inst_ret_last  = {1'b0, rlast};
    assign data_ret_last  = {1'b0, rlast};
    assign inst_ret_data  = rdata;
    assign data_ret_data  = rdata;

    // ---------------- write path ----------------
    assign data_wr_rdy = (wr_state == WR_IDLE) && !reset;
    assign wr_accept   = data_wr_rdy && data_wr_req;
    assign wr_ls       = type_to_len_size(data_wr_type);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awaddr <= '0;
            awlen  <= '0;
            awsize <= '0;
        end else if (wr_accept) begin
            awaddr <= data_wr_addr;
            awlen  <= wr_ls.len;
            awsize <= wr_ls.size;
        end
    end

    assign awvalid   = (wr_state == WR_SEND) && !aw_done;
    assign wvalid    = (wr_state == WR_SEND) && !w_done;
    assign aw_hs     = awvalid && awready;
    assign w_last_hs = wvalid && wready && wlast;
    assign bready    = (wr_state == WR_B);

    // AW and W-last may complete in either order; each is remembered until both are done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (wr_accept) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs)     aw_done <= 1'b1;
            if (w_last_hs) w_done  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_state <= WR_IDLE;
        else       wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (data_wr_req) wr_next = WR_SEND;
            WR_SEND: if ((aw_done || aw_hs) && (w_done || w_last_hs)) wr_next = WR_B;
            WR_B:    if (bvalid) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    assign awid    = ID_DATA;
    assign wid     = ID_DATA;
    assign awburst = BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;

    bridge_wr_buffer u_wr_buffer (
        .clk        (clk),
        .reset      (reset),
        .load       (wr_accept),
        .load_type  (data_wr_type),
        .load_wstrb (data_wr_wstrb),
        .load_data  (data_wr_data),
        .beat_fire  (wvalid && wready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast)
    );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed self-checking bench for cache_axi_bridge; the AXI slave is driven by hand.
module tb_cache_axi_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         inst_rd_req, data_rd_req, data_wr_req;
    logic [2:0]   inst_rd_type, data_rd_type, data_wr_type;
    logic [31:0]  inst_rd_addr, data_rd_addr, data_wr_addr;
    logic [3:0]   data_wr_wstrb;
    logic [127:0] data_wr_data;
    logic         inst_rd_rdy, inst_ret_valid, data_rd_rdy, data_ret_valid, data_wr_rdy;
    logic [1:0]   inst_ret_last, data_ret_last;
    logic [31:0]  inst_ret_data, data_ret_data;
    logic [3:0]   arid, awid, wid, rid, bid, arcache, awcache, wstrb;
    logic [31:0]  araddr, awaddr, rdata, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize, arprot, awprot;
    logic [1:0]   arburst, awburst, arlock, awlock, rresp, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int errors = 0;
    int checks = 0;

`ifdef BRIDGE_RAW_LINE_CHECK_EN
    localparam bit LINE_CHECK = 1'b1;
`else
    localparam bit LINE_CHECK = 1'b0;
`endif

    cache_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
        .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid),
        .inst_ret_last(inst_ret_last), .inst_ret_data(inst_ret_data),
        .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
        .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid),
        .data_ret_last(data_ret_last), .data_ret_data(data_ret_data),
        .data_wr_req(data_wr_req), .data_wr_type(data_wr_type), .data_wr_addr(data_wr_addr),
        .data_wr_wstrb(data_wr_wstrb), .data_wr_data(data_wr_data), .data_wr_rdy(data_wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read: request, AR handshake, then beats of seed*(i+1) with matching rid.
    task automatic read_txn(input bit is_data, input logic [31:0] addr, input logic [2:0] typ,
                            input logic [31:0] seed);
        int unsigned n;
        n = (typ == 3'b100) ? 4 : 1;
        if (is_data) begin
            data_rd_req = 1'b1; data_rd_addr = addr; data_rd_type = typ;
        end else begin
            inst_rd_req = 1'b1; inst_rd_addr = addr; inst_rd_type = typ;
        end
        #1;
        chk("rd_rdy", is_data ? data_rd_rdy : inst_rd_rdy, 1);
        tick();
        if (is_data) data_rd_req = 1'b0;
        else         inst_rd_req = 1'b0;
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, addr);
        chk("arid", arid, is_data ? 4'd1 : 4'd0);
        chk("arlen", arlen, 8'(n - 1));
        chk("arsize", arsize, (typ == 3'b100) ? 3'd2 : {1'b0, typ[1:0]});
        chk("arburst", arburst, 2'b01);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("arvalid_drop", arvalid, 0);
        chk("rready", rready, 1);
        for (int unsigned i = 0; i < n; i++) begin
            rvalid = 1'b1;
            rid    = is_data ? 4'd1 : 4'd0;
            rdata  = 32'(seed * (i + 1));
            rlast  = (i == n - 1);
            #1;
            chk("ret_valid", is_data ? data_ret_valid : inst_ret_valid, 1);
            chk("ret_other", is_data ? inst_ret_valid : data_ret_valid, 0);
            chk("ret_data", is_data ? data_ret_data : inst_ret_data, 32'(seed * (i + 1)));
            chk("ret_last", is_data ? data_ret_last : inst_ret_last, (i == n - 1) ? 2'b01 : 2'b00);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        chk("rready_idle", rready, 0);
    endtask

    initial begin
        reset = 1'b1;
        inst_rd_req = 1'b1; inst_rd_type = 3'b100; inst_rd_addr = '0;
        data_rd_req = 1'b1; data_rd_type = 3'b010; data_rd_addr = '0;
        data_wr_req = 1'b1; data_wr_type = 3'b010; data_wr_addr = '0;
        data_wr_wstrb = '0; data_wr_data = '0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        // Reset state, with requests asserted
        tick(); tick();
        chk("rst_data_rd_rdy", data_rd_rdy, 0);
        chk("rst_inst_rd_rdy", inst_rd_rdy, 0);
        chk("rst_data_wr_rdy", data_wr_rdy, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_ret_valid", {inst_ret_valid, data_ret_valid}, 0);
        inst_rd_req = 0; data_rd_req = 0; data_wr_req = 0;
        reset = 1'b0;
        tick();
        chk("idle_data_wr_rdy", data_wr_rdy, 1);

        // Data line read
        read_txn(1'b1, 32'h1C00_0010, 3'b100, 32'h11);

        // Simultaneous inst + data: data wins, inst follows
        inst_rd_req = 1'b1; inst_rd_addr = 32'h0000_1000; inst_rd_type = 3'b100;
        data_rd_req = 1'b1; data_rd_addr = 32'h0000_2000; data_rd_type = 3'b010;
        #1;
        chk("arb_data_rdy", data_rd_rdy, 1);
        chk("arb_inst_rdy", inst_rd_rdy, 0);
        read_txn(1'b1, 32'h0000_2000, 3'b010, 32'h5A5A_0001);
        read_txn(1'b0, 32'h0000_1000, 3'b100, 32'h0101_0101);

        // Line write, AW ready after all W beats
        data_wr_type = 3'b100; data_wr_addr = 32'h0000_0100; data_wr_wstrb = 4'h0;
        data_wr_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        data_wr_req = 1'b1;
        #1;
        chk("lw_wr_rdy", data_wr_rdy, 1);
        tick();
        data_wr_req = 1'b0;
        chk("lw_awvalid", awvalid, 1);
        chk("lw_awaddr", awaddr, 32'h100);
        chk("lw_awlen", awlen, 3);
        chk("lw_awsize", awsize, 2);
        chk("lw_awburst", awburst, 2'b01);
        chk("lw_ids", {awid, wid}, 8'h11);
        chk("lw_wr_rdy_busy", data_wr_rdy, 0);
        wready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            #1;
            chk("lw_wvalid", wvalid, 1);
            chk("lw_wdata", wdata, 32'(32'h1111_1111 * (i + 1)));
            chk("lw_wstrb", wstrb, 4'hf);
            chk("lw_wlast", wlast, (i == 3));
            tick();
        end
        wready = 1'b0;
        chk("lw_wvalid_drop", wvalid, 0);
        chk("lw_aw_pending", awvalid, 1);
        chk("lw_no_b_early", bready, 0);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("lw_awvalid_drop", awvalid, 0);
        chk("lw_bready", bready, 1);
        bvalid = 1'b1;
        #1;
        chk("lw_wr_rdy_in_b", data_wr_rdy, 0);
        tick();
        bvalid = 1'b0;
        chk("lw_wr_rdy_back", data_wr_rdy, 1);
        chk("lw_bready_drop", bready, 0);

        // Word store
        data_wr_type = 3'b010; data_wr_addr = 32'hBFAF_0000; data_wr_wstrb = 4'b0110;
        data_wr_data = 128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DEAD_BEEF;
        data_wr_req = 1'b1;
        #1;
        tick();
        data_wr_req = 1'b0;
        chk("ws_awaddr", awaddr, 32'hBFAF_0000);
        chk("ws_awlen", awlen, 0);
        chk("ws_awsize", awsize, 2);
        chk("ws_wdata", wdata, 32'hDEAD_BEEF);
        chk("ws_wstrb", wstrb, 4'b0110);
        chk("ws_wlast", wlast, 1);
        chk("ws_wvalid", wvalid, 1);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        chk("ws_bready", bready, 1);
        chk("ws_idle_aw_w", {awvalid, wvalid}, 0);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("ws_wr_rdy", data_wr_rdy, 1);

        // Read-after-write block
        data_wr_type = 3'b100; data_wr_addr = 32'h0000_0100; data_wr_data = 128'h1;
        data_wr_req = 1'b1;
        data_rd_req = 1'b1; data_rd_addr = 32'h0000_0108; data_rd_type = 3'b010;
        #1;
        chk("raw_incoming_same", data_rd_rdy, 0);
        tick();
        data_wr_req = 1'b0;
        chk("raw_pending_same", data_rd_rdy, 0);
        data_rd_addr = 32'h0000_0200;
        #1;
        chk("raw_pending_other", data_rd_rdy, LINE_CHECK);
        data_rd_req = 1'b0;
        if (LINE_CHECK) read_txn(1'b1, 32'h0000_0200, 3'b010, 32'h0000_0055);
        data_rd_req = 1'b1; data_rd_addr = 32'h0000_0108;
        awready = 1'b1; wready = 1'b1;
        tick(); tick(); tick(); tick();
        awready = 1'b0; wready = 1'b0;
        chk("raw_in_wr_b", bready, 1);
        chk("raw_blocked_b", data_rd_rdy, 0);
        bvalid = 1'b1;
        #1;
        chk("raw_blocked_bvalid", data_rd_rdy, 0);
        tick();
        bvalid = 1'b0;
        #1;
        chk("raw_released", data_rd_rdy, 1);
        read_txn(1'b1, 32'h0000_0108, 3'b010, 32'h0000_0066);

        // Reset during RD_R after two beats
        inst_rd_req = 1'b1; inst_rd_addr = 32'h0000_3000; inst_rd_type = 3'b100;
        #1;
        tick();
        inst_rd_req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hCAFE_0000;
        #1;
        chk("mid_ret_valid", inst_ret_valid, 1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_ret_valid", {inst_ret_valid, data_ret_valid}, 0);
        rvalid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        read_txn(1'b1, 32'h0000_0044, 3'b010, 32'h0000_0077);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
